mem_port_arbiter: RTL

Sequences the single byte-wide RAM port between three requesters: the instruction fetcher, the load buffer and the committed-store path from the reorder buffer. Each requester holds a level request with stable operands until a one-cycle ack. The block arbitrates, serialises 1/2/4-byte accesses onto `mem_a`/`mem_din`/`mem_dout`/`mem_wr`, assembles and sign-extends read data, and throttles UART stores. It sits between the fetcher/LSB/ROB and the top-level RAM/IO bus.

---
 rtl/mem_port_arbiter.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Byte-wide RAM port arbiter for fetch, load and committed-store traffic.
// Define MEM_ARB_AGING_EN to let a starved fetch override store/load priority.
module mem_port_arbiter #(
  parameter int unsigned AGE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        flush,
  input  logic        io_buffer_full,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  input  logic [2:0]  ld_size,
  input  logic        ld_signed,
  output logic        ld_ack,
  input  logic        st_req,
  input  logic [31:0] st_addr,
  input  logic [2:0]  st_size,
  input  logic [31:0] st_data,
  output logic        st_ack,
  output logic [31:0] rd_data,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  output logic [1:0]  grant
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRead  = 2'd1;
  localparam logic [1:0] StWrite = 2'd2;

  localparam logic [1:0] GrNone  = 2'd0;
  localparam logic [1:0] GrFetch = 2'd1;
  localparam logic [1:0] GrLoad  = 2'd2;
  localparam logic [1:0] GrStore = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [1:0]  k_q, k_d;
  logic [31:0] asm_q, asm_d;
  logic [31:0] data_q, data_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        mem_wr_q, mem_wr_d;
  logic        if_ack_q, if_ack_d;
  logic        ld_ack_q, ld_ack_d;
  logic        st_ack_q, st_ack_d;
  logic [1:0]  cool_q, cool_d;
  logic [3:0]  age_q, age_d;

  logic        st_blocked;
  logic        last_byte;
  logic [31:0] asm_next;
  logic [31:0] ext_word;
  logic [1:0]  pick;
  logic [3:0]  age_inc;

  function automatic logic [2:0] decode_size(input logic [2:0] s);
    case (s)
      3'd1:    decode_size = 3'd1;
      3'd2:    decode_size = 3'd2;
      default: decode_size = 3'd4;
    endcase
  endfunction

  // A blocked UART store also holds back loads so they cannot pass it.
  assign st_blocked = (st_addr[17:16] == 2'b11) && (io_buffer_full || (cool_q != 2'd0));
  assign last_byte  = ({1'b0, k_q} == (size_q - 3'd1));
  assign asm_next   = asm_q | (32'(mem_din) << {k_q, 3'b000});
  assign age_inc    = ((age_q != 4'hf) && (32'(age_q) < AGE_LIMIT)) ? age_q + 4'd1 : age_q;

  always_comb begin
    ext_word = asm_next;
    if (grant_q == GrLoad) begin
      case (size_q)
        3'd1:    ext_word = {{24{signed_q & asm_next[7]}}, asm_next[7:0]};
        3'd2:    ext_word = {{16{signed_q & asm_next[15]}}, asm_next[15:0]};
        default: ext_word = asm_next;
      endcase
    end
  end

  always_comb begin
    pick = GrNone;
    if (st_req && !st_blocked) begin
      pick = GrStore;
    end else if (ld_req && !st_req) begin
      pick = GrLoad;
    end else if (if_req) begin
      pick = GrFetch;
    end
`ifdef MEM_ARB_AGING_EN
    if (if_req && (32'(age_q) >= AGE_LIMIT)) begin
      pick = GrFetch;
    end
`endif
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    addr_d     = addr_q;
    size_d     = size_q;
    signed_d   = signed_q;
    k_d        = k_q;
    asm_d      = asm_q;
    data_d     = data_q;
    rd_data_d  = rd_data_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = mem_wr_q;
    if_ack_d   = if_ack_q;
    ld_ack_d   = ld_ack_q;
    st_ack_d   = st_ack_q;
    cool_d     = cool_q;
    age_d      = age_q;

    if (rdy) begin
      if_ack_d = 1'b0;
      ld_ack_d = 1'b0;
      st_ack_d = 1'b0;
      mem_wr_d = 1'b0;
      if (cool_q != 2'd0) begin
        cool_d = cool_q - 2'd1;
      end
      if (flush) begin
        rd_data_d = 32'd0;
        age_d     = 4'd0;
      end

      case (state_q)
        StIdle: begin
          if (!flush && (pick != GrNone)) begin
            grant_d = pick;
            k_d     = 2'd0;
            asm_d   = 32'd0;
            case (pick)
              GrFetch: begin
                addr_d   = if_addr;
                size_d   = 3'd4;
                signed_d = 1'b0;
                state_d  = StRead;
                age_d    = 4'd0;
              end
              GrLoad: begin
                addr_d   = ld_addr;
                size_d   = decode_size(ld_size);
                signed_d = ld_signed;
                state_d  = StRead;
                if (if_req) age_d = age_inc;
              end
              default: begin
                addr_d   = st_addr;
                size_d   = decode_size(st_size);
                signed_d = 1'b0;
                data_d   = st_data;
                state_d  = StWrite;
                if (if_req) age_d = age_inc;
              end
            endcase
            mem_a_d = addr_d;
          end
        end
        StRead: begin
          if (flush) begin
            state_d = StIdle;
            grant_d = GrNone;
          end else begin
            asm_d = asm_next;
            k_d   = k_q + 2'd1;
            if (last_byte) begin
              state_d   = StIdle;
              grant_d   = GrNone;
              rd_data_d = ext_word;
              if_ack_d  = (grant_q == GrFetch);
              ld_ack_d  = (grant_q == GrLoad);
            end else begin
              mem_a_d = mem_a_q + 32'd1;
            end
          end
        end
        StWrite: begin
          // Committed stores are architecturally visible, so flush never cuts them short.
          mem_wr_d   = 1'b1;
          mem_a_d    = addr_q + {30'd0, k_q};
          mem_dout_d = data_q[{k_q, 3'b000} +: 8];
          k_d        = k_q + 2'd1;
          if (last_byte) begin
            st_ack_d = 1'b1;
            state_d  = StIdle;
            grant_d  = GrNone;
            if (addr_q[17:16] == 2'b11) cool_d = 2'd2;
          end
        end
        default: begin
          state_d = StIdle;
          grant_d = GrNone;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      grant_q    <= GrNone;
      addr_q     <= 32'd0;
      size_q     <= 3'd0;
      signed_q   <= 1'b0;
      k_q        <= 2'd0;
      asm_q      <= 32'd0;
      data_q     <= 32'd0;
      rd_data_q  <= 32'd0;
      mem_a_q    <= 32'd0;
      mem_dout_q <= 8'd0;
      mem_wr_q   <= 1'b0;
      if_ack_q   <= 1'b0;
      ld_ack_q   <= 1'b0;
      st_ack_q   <= 1'b0;
      cool_q     <= 2'd0;
      age_q      <= 4'd0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      signed_q   <= signed_d;
      k_q        <= k_d;
      asm_q      <= asm_d;
      data_q     <= data_d;
      rd_data_q  <= rd_data_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
      if_ack_q   <= if_ack_d;
      ld_ack_q   <= ld_ack_d;
      st_ack_q   <= st_ack_d;
      cool_q     <= cool_d;
      age_q      <= age_d;
    end
  end

  // A stalled write byte is masked, then reappears unchanged once rdy returns.
  assign mem_wr   = mem_wr_q & rdy;
  assign mem_a    = mem_a_q;
  assign mem_dout = mem_dout_q;
  assign rd_data  = rd_data_q;
  assign grant    = grant_q;
  assign if_ack   = if_ack_q;
  assign ld_ack   = ld_ack_q;
  assign st_ack   = st_ack_q;

endmodule
